// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and state type for the SIPO deserializer
// Purpose : default word width and the count-derived state enum.
// Contents: SIPO_WIDTH (default WIDTH), sipo_state_e (IDLE, COLLECT).
package sipo_pkg;

    localparam int SIPO_WIDTH = 8;

    // IDLE while the bit count is zero, COLLECT while a partial word is held.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } sipo_state_e;

endpackage

// File: rtl/sipo_holding_reg.sv
// rtl/sipo_holding_reg.sv - one-word valid/ready output register with overrun detect
// Purpose : holds one completed word until the consumer accepts it; a word
//           arriving while the register is full and not being drained is
//           dropped and flagged on a sticky overrun.
// Ports   : clk, reset (sync, active-high)
//           load_i/load_data_i  - a completed word is offered this cycle
//           ready_i             - consumer accepts when valid_o && ready_i
//           clr_overrun_i       - clears overrun_o (a new drop wins)
//           data_o/valid_o      - held word and its valid flag
//           overrun_o           - sticky dropped-word flag
module sipo_holding_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          ready_i,
    input  logic          clr_overrun_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          overrun_o
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          accept;
    logic          slot_free;

    assign accept    = valid_q && ready_i;
    // A word can be taken if the slot is empty or is emptied this same cycle.
    assign slot_free = !valid_q || accept;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load_i && slot_free) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        // Set has priority over clear so a drop is never lost.
        if (load_i && !slot_free) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - MSB-first serial-to-parallel deserializer
// Purpose : samples serial_in on shift, assembles WIDTH-bit words and hands
//           them to a one-word valid/ready holding register.
// Ports   : clk, reset (sync, active-high)
//           serial_in, shift, sync       - serial stream, bit strobe, word start
//           out_data, out_valid, out_ready - parallel word handshake
//           overrun, clr_overrun          - sticky drop flag and its clear
//           busy                          - partial word in progress
//           parity_err                    - only with SIPO_PARITY_EN
// Macro   : SIPO_PARITY_EN - frames carry a trailing even-parity bit.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             shift,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

`ifdef SIPO_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_LEN = WIDTH + PAR_W;
    localparam int SREG_W    = FRAME_LEN - 1;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int DW        = WIDTH + PAR_W;

    logic [SREG_W-1:0]    sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    sipo_state_e          state_q, state_d;
    logic [FRAME_LEN-1:0] frame;
    logic                 word_done;
    logic [DW-1:0]        load_word;
    logic [DW-1:0]        hold_data;

    // The final bit of a frame is never stored; the frame is completed
    // combinationally from the shift register plus the bit being sampled.
    assign frame = {sreg_q, serial_in};

    always_comb begin
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (shift) begin
            if (sync) begin
                // Sync restarts framing and abandons any pending completion.
                sreg_d = SREG_W'(serial_in);
                cnt_d  = CNT_W'(1);
            end else begin
                sreg_d = (sreg_q << 1) | SREG_W'(serial_in);
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
        state_d = (cnt_d == '0) ? IDLE : COLLECT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign busy = (state_q == COLLECT);

`ifdef SIPO_PARITY_EN
    // Even parity: the XOR over data plus parity bit is 0 for a good frame.
    assign load_word  = {frame[FRAME_LEN-1:1], ^frame};
    assign out_data   = hold_data[DW-1:1];
    assign parity_err = hold_data[0];
`else
    assign load_word  = frame;
    assign out_data   = hold_data;
`endif

    sipo_holding_reg #(
        .DW (DW)
    ) u_hold (
        .clk           (clk),
        .reset         (reset),
        .load_i        (word_done),
        .load_data_i   (load_word),
        .ready_i       (out_ready),
        .clr_overrun_i (clr_overrun),
        .data_o        (hold_data),
        .valid_o       (out_valid),
        .overrun_o     (overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed self-checking bench for sipo_deserializer
module tb_sipo_deserializer;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic       shift;
    logic       sync;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       clr_overrun;
    logic       busy;
`ifdef SIPO_PARITY_EN
    logic       parity_err;
`endif

    int n_total = 0;
    int n_pass  = 0;

    sipo_deserializer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .shift       (shift),
        .sync        (sync),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
`ifdef SIPO_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        shift     = 1'b1;
        serial_in = b;
        sync      = s;
        tick();
        shift     = 1'b0;
        sync      = 1'b0;
    endtask

    // Even parity bit for a data byte (only sent in parity builds).
    task automatic send_par(input logic p);
`ifdef SIPO_PARITY_EN
        send_bit(p, 1'b0);
`else
        if (p === 1'bx) $display("unused parity arg");
`endif
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
        send_par(^w);
    endtask

    initial begin
        logic [7:0] w;
        reset = 1'b1; serial_in = 1'b0; shift = 1'b0; sync = 1'b0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        tick(); tick();
        check("rst_valid",   out_valid, 0);
        check("rst_data",    out_data,  0);
        check("rst_overrun", overrun,   0);
        check("rst_busy",    busy,      0);
        reset = 1'b0;

        // 1: 0xCC continuous, consumer ready
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        check("t1_busy_first", busy, 1);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        check("t1_valid_early", out_valid, 0);
        send_bit(1'b0, 1'b0);
        send_par(1'b0);
        check("t1_valid", out_valid, 1);
        check("t1_data",  out_data,  8'hCC);
        check("t1_ovr",   overrun,   0);
        check("t1_busy_end", busy,   0);
`ifdef SIPO_PARITY_EN
        check("t1_perr", parity_err, 0);
`endif
        tick();
        check("t1_valid_drop", out_valid, 0);

        // 2: 0xCC with a 3-cycle gap after bit 4
        w = 8'hCC;
        for (int i = 7; i >= 4; i--) send_bit(w[i], 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("t2_busy_gap", busy, 1);
        end
        check("t2_valid_gap", out_valid, 0);
        for (int i = 3; i >= 0; i--) send_bit(w[i], 1'b0);
        send_par(1'b0);
        check("t2_valid", out_valid, 1);
        check("t2_data",  out_data,  8'hCC);
        tick();

        // 3: stalled consumer, overrun and clear
        out_ready = 1'b0;
        send_word(8'hA5);
        check("t3_valid_a5", out_valid, 1);
        check("t3_data_a5",  out_data,  8'hA5);
        check("t3_ovr_a5",   overrun,   0);
        send_word(8'h3C);
        check("t3_data_hold", out_data,  8'hA5);
        check("t3_ovr_set",   overrun,   1);
        check("t3_valid_hold", out_valid, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t3_ovr_clr",  overrun,   0);
        check("t3_valid_still", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("t3_valid_drop", out_valid, 0);
        check("t3_ovr_stay0",  overrun,   0);

        // 4: partial word then resync with 0xF0
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        check("t4_busy_part", busy, 1);
        w = 8'hF0;
        send_bit(w[7], 1'b1);
        send_bit(w[6], 1'b0);
        send_bit(w[5], 1'b0);
        check("t4_no_partial", out_valid, 0);
        for (int i = 4; i >= 0; i--) send_bit(w[i], 1'b0);
        send_par(1'b0);
        check("t4_valid", out_valid, 1);
        check("t4_data",  out_data,  8'hF0);
        tick();

        // 5: 0x12 then 0x34, ready only on 0x34's completion cycle
        out_ready = 1'b0;
        send_word(8'h12);
        check("t5_data_12", out_data, 8'h12);
        w = 8'h34;
`ifdef SIPO_PARITY_EN
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
        out_ready = 1'b1;
        send_bit(^w, 1'b0);
`else
        for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
        out_ready = 1'b1;
        send_bit(w[0], 1'b0);
`endif
        out_ready = 1'b0;
        check("t5_data_34",  out_data,  8'h34);
        check("t5_valid_34", out_valid, 1);
        check("t5_ovr",      overrun,   0);
        out_ready = 1'b1;
        tick();
        check("t5_drain", out_valid, 0);

        // 6: back-to-back throughput with ready high
        send_word(8'h5A);
        check("t6_data_5a", out_data, 8'h5A);
        send_word(8'hC3);
        check("t6_data_c3", out_data, 8'hC3);
        check("t6_ovr",     overrun,  0);
        tick();

        // 7: reset mid-word, then 0x81
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        reset = 1'b1;
        shift = 1'b1; serial_in = 1'b1;
        tick();
        shift = 1'b0;
        reset = 1'b0;
        check("t7_busy_rst",  busy,      0);
        check("t7_valid_rst", out_valid, 0);
        w = 8'h81;
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(1'b1, 1'b0);
        check("t7_perr", parity_err, 1);
`endif
        check("t7_data",  out_data,  8'h81);
        check("t7_valid", out_valid, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
